// File: rtl/s_serial_adder16.sv
// Bit-serial adder: a+b+cin over WIDTH edges using one gate-level full-adder slice.
// Latency WIDTH+1 edges from accept to out_valid; one operand set in flight at a time.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, one bubble between results.
//
// Ports: clk, reset (sync, active-high); in_valid/in_ready + a, b, cin operand handshake;
//        out_valid/out_ready + sum, cout, overflow result handshake; busy high while shifting.
module s_serial_adder16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);

  // One extra bit so the counter can reach WIDTH without wrapping.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] acc_next;

  s_full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_c)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 has reached position 0.
  assign acc_next = {fa_s, acc[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      acc       <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            carry    <= cin;
            acc      <= '0;
            cnt      <= '0;
            state    <= SHIFT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end

        SHIFT: begin
          a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          acc   <= acc_next;
          carry <= fa_c;
          cnt   <= cnt + {{(CW-1){1'b0}}, 1'b1};
          if (cnt == LAST) begin
            // carry still holds the carry into the MSB at this edge.
            sum       <= acc_next;
            cout      <= fa_c;
            overflow  <= carry ^ fa_c;
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end

        DONE: begin
          // Returning to IDLE costs one edge, so no accept can coincide with release.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// Two-input NAND: the primitive every other gate below is derived from.
module s_nand (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

// AND as NAND followed by a NAND wired as an inverter.
module s_and (
  input  logic a,
  input  logic b,
  output logic y
);
  logic n;
  s_nand u_n0 (.a(a), .b(b), .y(n));
  s_nand u_n1 (.a(n), .b(n), .y(y));
endmodule

// OR by De Morgan: NAND of the inverted inputs.
module s_or (
  input  logic a,
  input  logic b,
  output logic y
);
  logic na;
  logic nb;
  s_nand u_ia (.a(a),  .b(a),  .y(na));
  s_nand u_ib (.a(b),  .b(b),  .y(nb));
  s_nand u_o  (.a(na), .b(nb), .y(y));
endmodule

// Classic four-NAND XOR.
module s_xor (
  input  logic a,
  input  logic b,
  output logic y
);
  logic n0;
  logic n1;
  logic n2;
  s_nand u_n0 (.a(a),  .b(b),  .y(n0));
  s_nand u_n1 (.a(a),  .b(n0), .y(n1));
  s_nand u_n2 (.a(b),  .b(n0), .y(n2));
  s_nand u_n3 (.a(n1), .b(n2), .y(y));
endmodule

// Single bit-slice full adder: s = a^b^ci, co = a&b | ci&(a^b).
module s_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;
  logic g;
  logic t;
  s_xor u_p  (.a(a), .b(b),  .y(p));
  s_xor u_s  (.a(p), .b(ci), .y(s));
  s_and u_g  (.a(a), .b(b),  .y(g));
  s_and u_t  (.a(p), .b(ci), .y(t));
  s_or  u_co (.a(g), .b(t),  .y(co));
endmodule

// File: tb/tb_s_serial_adder16.sv
// Directed bench for s_serial_adder16 (WIDTH=16): results, latency, stall, reset abort.
// Inputs driven and outputs sampled on the falling edge.
// Bench holds out_ready low until it has checked each result.
module tb_s_serial_adder16;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        overflow;
  logic        busy;

  int tests = 0;
  int fails = 0;

  logic [15:0] last_sum;
  logic        last_cout;
  logic        last_ovf;

  s_serial_adder16 #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer operands for one edge; on return we sit at the falling edge after the accept.
  task automatic start_op(input logic [15:0] va, input logic [15:0] vb, input logic vc);
    a        = va;
    b        = vb;
    cin      = vc;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_in_ready", in_ready, 0);
    check("mid_sum_retained", sum, last_sum);
  endtask

  // Count edges after the accept until out_valid; must be exactly 16.
  task automatic wait_done();
    int k;
    k = 0;
    while (out_valid !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("latency", k, 16);
  endtask

  task automatic check_res(input string tag, input logic [15:0] es, input logic ec, input logic eo);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, overflow, eo);
    last_sum  = es;
    last_cout = ec;
    last_ovf  = eo;
  endtask

  task automatic release_res();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
  endtask

  task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                        input logic vc, input logic [15:0] es, input logic ec, input logic eo);
    start_op(va, vb, vc);
    wait_done();
    check_res(tag, es, ec, eo);
    release_res();
  endtask

  initial begin
    int saw_valid;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 16'h0;
    b         = 16'h0;
    cin       = 1'b0;
    last_sum  = 16'h0;
    last_cout = 1'b0;
    last_ovf  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 16'h0000);
    check("rst_cout", cout, 0);
    check("rst_ovf", overflow, 0);

    // Unsigned wrap, signed overflow both ways, carry-in only, no-carry add.
    run_op("wrap",    16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("posovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("negovf",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_op("cinonly", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
    run_op("mixed",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("allones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    run_op("minm1",   16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1);

    // Stall in DONE for 10 cycles while new operands are offered.
    start_op(16'h00FF, 16'h0F0F, 1'b0);
    wait_done();
    check_res("bp", 16'h100E, 1'b0, 1'b0);
    a        = 16'h2222;
    b        = 16'h1111;
    cin      = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_sum_stable", sum, 16'h100E);
      check("bp_cout_stable", cout, 0);
      check("bp_ovf_stable", overflow, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_rel_out_valid", out_valid, 0);
    check("bp_rel_in_ready", in_ready, 1);
    check("bp_rel_no_accept", busy, 0);
    // in_valid still high: accept happens on the following edge.
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_next_accept", busy, 1);
    wait_done();
    check_res("bp2", 16'h3334, 1'b0, 1'b0);
    release_res();

    // Reset while shifting with counter at 7 discards the operation.
    start_op(16'h1234, 16'h1111, 1'b0);
    repeat (7) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_sum", sum, 16'h0000);
    check("abort_cout", cout, 0);
    check("abort_ovf", overflow, 0);
    last_sum  = 16'h0000;
    last_cout = 1'b0;
    last_ovf  = 1'b0;
    saw_valid = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid === 1'b1) saw_valid = 1;
    end
    check("abort_no_result", saw_valid, 0);
    run_op("post_rst", 16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/s_serial_adder16.md
S_SERIAL_ADDER16 -- requirements
Module: s_serial_adder16

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 16, operand/result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset, input, 1, reset; one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1, operand set offered.
REQ-005 The block SHALL have port in_ready, output, 1, block can accept operands.
REQ-006 The block SHALL have port a, input, WIDTH, operand A (two's complement or unsigned).
REQ-007 The block SHALL have port b, input, WIDTH, operand B.
REQ-008 The block SHALL have port cin, input, 1, carry-in for bit 0.
REQ-009 The block SHALL have port out_valid, output, 1, result available.
REQ-010 The block SHALL have port out_ready, input, 1, consumer takes result.
REQ-011 The block SHALL have port sum, output, WIDTH, a+b+cin modulo 2^WIDTH.
REQ-012 The block SHALL have port cout, output, 1, carry out of the MSB.
REQ-013 The block SHALL have port overflow, output, 1, signed overflow flag.
REQ-014 The block SHALL have port busy, output, 1, high in SHIFT state.

Function
REQ-015 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-016 in_ready SHALL be high only in IDLE; busy only in SHIFT; out_valid only in DONE.
REQ-017 Accept SHALL occur on an edge with state IDLE and in_valid=1: load a, b into shift registers, load cin into the carry flop, clear sum register and bit counter, go to SHIFT.
REQ-018 in_valid SHALL be ignored in SHIFT and DONE; a and b are sampled only at accept.
REQ-019 Each SHIFT edge SHALL add one bit: s = A[0] ^ B[0] ^ c, c' = A[0]&B[0] | c&(A[0]^B[0]); shift A and B right by one; shift s into sum MSB (sum register shifts right); counter increments.
REQ-020 The per-bit sum and carry logic SHALL be built from the team's sXOR, sAND and sNAND-derived gate modules, one bit-slice full adder.
REQ-021 At the SHIFT edge with counter=WIDTH-1, the block SHALL capture the carry into the MSB (pre-update c) for overflow, write final carry to cout, and go to DONE.
REQ-022 overflow SHALL equal (carry into MSB) XOR cout.
REQ-023 Latency SHALL be exactly WIDTH+1 edges: accept at edge E0, out_valid high after edge E(WIDTH).
REQ-024 In DONE, sum, cout, overflow SHALL hold stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-025 In DONE with out_ready=1 at an edge, the block SHALL go to IDLE; no new accept on that same edge (one bubble cycle minimum between results).
REQ-026 sum, cout, overflow SHALL retain the last result in IDLE and SHIFT until the next DONE updates them; sum register SHALL not be visible mid-shift (output from a separate result register loaded on entry to DONE).
REQ-027 Counter SHALL be ceil(log2(WIDTH))+1 bits and never wrap during an operation.
REQ-028 Unsigned wrap-around (e.g. 0xFFFF+0x0001) SHALL produce sum 0 with cout=1, no other effect.

Reset
REQ-029 reset=1 at an edge SHALL force state IDLE, counter 0, carry 0, shift registers 0, and outputs sum=0, cout=0, overflow=0, out_valid=0, busy=0, in_ready=1 after that edge.
REQ-030 reset SHALL take priority over accept, shift and output handshake; an operation in progress is discarded with no result emitted.
REQ-031 After reset is released, the block SHALL accept on the first edge with in_valid=1.

Verification
REQ-032 a=0x0001, b=0xFFFF, cin=0 -> after 17 edges: sum=0x0000, cout=1, overflow=0.
REQ-033 a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, overflow=1; a=0x8000, b=0x8000 -> sum=0x0000, cout=1, overflow=1.
REQ-034 a=0x0000, b=0x0000, cin=1 -> sum=0x0001, cout=0, overflow=0; a=0x1234, b=0x4321, cin=0 -> sum=0x5555.
REQ-035 Backpressure: hold out_ready=0 for 10 cycles in DONE with in_valid=1 -> outputs stable, in_ready=0, no second accept; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-036 Reset at SHIFT counter=7 -> next cycle IDLE, all outputs at reset values, no out_valid pulse; new operation afterwards gives correct result.
REQ-037 Randomized 1000 operand sets with random out_ready stalls -> every result matches a+b+cin reference, overflow per REQ-022, latency per REQ-023.
